// File: rtl/j1_boot_loader.sv
// Byte-stream program loader for the J1 RAM port B; holds the core in reset until a frame loads.
// Optional checksum byte and ERROR state enabled by defining J1_LOADER_CHECKSUM_EN.
module j1_boot_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        ram_write,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_data,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN_LO  = 3'd1;
    localparam logic [2:0] S_LEN_HI  = 3'd2;
    localparam logic [2:0] S_DATA_LO = 3'd3;
    localparam logic [2:0] S_DATA_HI = 3'd4;
    localparam logic [2:0] S_CSUM    = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
    localparam logic [2:0] S_ERROR   = 3'd7;

    logic [2:0]  state;
    logic [15:0] len;
    logic [15:0] count;
    logic [7:0]  lo;
    logic        xfer;

    // Bytes are never back-pressured; only the reset cycle refuses input.
    assign in_ready = ~reset;
    assign xfer     = in_valid & in_ready;

`ifdef J1_LOADER_CHECKSUM_EN
    logic [7:0] sum;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            ram_write <= 1'b0;
            ram_addr  <= 16'h0000;
            ram_data  <= 16'h0000;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            len       <= 16'h0000;
            count     <= 16'h0000;
            lo        <= 8'h00;
`ifdef J1_LOADER_CHECKSUM_EN
            sum       <= 8'h00;
`endif
        end else begin
            ram_write <= 1'b0;
            if (xfer) begin
                case (state)
                    S_IDLE: begin
                        if (in_data == SYNC_BYTE) state <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        len[7:0] <= in_data;
                        state    <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        len[15:8] <= in_data;
                        count     <= 16'h0000;
`ifdef J1_LOADER_CHECKSUM_EN
                        sum       <= 8'h00;
                        if ({in_data, len[7:0]} == 16'h0000) state <= S_CSUM;
                        else                                 state <= S_DATA_LO;
`else
                        if ({in_data, len[7:0]} == 16'h0000) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            error     <= 1'b0;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= S_DATA_LO;
                        end
`endif
                    end
                    S_DATA_LO: begin
                        lo    <= in_data;
`ifdef J1_LOADER_CHECKSUM_EN
                        sum   <= csum_add(sum, in_data);
`endif
                        state <= S_DATA_HI;
                    end
                    S_DATA_HI: begin
                        // Address wraps naturally in 16 bits.
                        ram_write <= 1'b1;
                        ram_data  <= {in_data, lo};
                        ram_addr  <= BASE_ADDR + count;
                        count     <= count + 16'd1;
`ifdef J1_LOADER_CHECKSUM_EN
                        sum       <= csum_add(sum, in_data);
                        if (count + 16'd1 == len) state <= S_CSUM;
                        else                      state <= S_DATA_LO;
`else
                        if (count + 16'd1 == len) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            error     <= 1'b0;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= S_DATA_LO;
                        end
`endif
                    end
`ifdef J1_LOADER_CHECKSUM_EN
                    S_CSUM: begin
                        if (in_data == sum) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            error     <= 1'b0;
                            cpu_reset <= 1'b0;
                        end else begin
                            state     <= S_ERROR;
                            done      <= 1'b0;
                            error     <= 1'b1;
                            cpu_reset <= 1'b1;
                        end
                    end
`endif
                    S_DONE, S_ERROR: begin
                        // A new SYNC restarts the load and re-holds the core.
                        if (in_data == SYNC_BYTE) begin
                            state     <= S_LEN_LO;
                            cpu_reset <= 1'b1;
                            done      <= 1'b0;
                            error     <= 1'b0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
